// File: rtl/framer_pkg.sv
// Shared types and constants for the sample UART framer.
package framer_pkg;

  localparam int unsigned DROP_W    = 16;
  localparam int unsigned MAX_BYTES = 8;
  localparam int unsigned SYNC_W    = 8 * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } framer_state_t;

  // Most-negative two's-complement value for a word of num_bytes bytes.
  function automatic logic [SYNC_W-1:0] sync_word(input int unsigned num_bytes);
    return SYNC_W'(1) << (8 * num_bytes - 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra wrap bit to tell full from empty.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sample_uart_framer.sv
// Buffers samples, clamps them off the sync value, and feeds the UART transmitter
// one word at a time with a sync word at the start of every frame.
module sample_uart_framer
  import framer_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_LEN  = 256
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [8*NUM_BYTES-1:0]        sample_in,
  input  logic                          sample_valid_in,
  input  logic                          tx_busy_in,
  output logic [NUM_BYTES-1:0][7:0]     tx_data_out,
  output logic                          tx_trigger_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic [DROP_W-1:0]             drop_count_out,
  output logic                          busy_out
);

  localparam int unsigned DATA_W = 8 * NUM_BYTES;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FRM_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [DATA_W-1:0] SYNC     = DATA_W'(sync_word(NUM_BYTES));
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(FRAME_LEN - 1);

  framer_state_t     state;
  framer_state_t     state_n;
  logic [FRM_W-1:0]  frame_cnt;
  logic              sync_sent;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] clamped_c;
  logic              full;
  logic              empty;
  logic              sync_due_c;
  logic              go_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic [CNT_W-1:0]  count_n_c;
  logic              busy_n_c;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (push_c),
    .pop      (pop_c),
    .wdata    (clamped_c),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count_out)
  );

  // Arbitration: a sync only goes out when a sample is waiting behind it.
  always_comb begin
    clamped_c  = (sample_in == SYNC) ? SYNC + DATA_W'(1) : sample_in;
    sync_due_c = (frame_cnt == '0) && !sync_sent;
    go_c       = (state == IDLE) && !tx_busy_in && !empty;
    pop_c      = go_c && !sync_due_c;
    push_c     = sample_valid_in && (!full || pop_c);
    drop_c     = sample_valid_in && full && !pop_c;
    count_n_c  = fifo_count_out + CNT_W'(push_c) - CNT_W'(pop_c);
    state_n    = state;
    case (state)
      IDLE:    if (go_c)       state_n = WAIT_HI;
      WAIT_HI: if (tx_busy_in) state_n = WAIT_LO;
      WAIT_LO: if (!tx_busy_in) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n_c = (state_n != IDLE) || (count_n_c != '0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      sync_sent      <= 1'b0;
      tx_data_out    <= '0;
      tx_trigger_out <= 1'b0;
      drop_count_out <= '0;
      busy_out       <= 1'b0;
    end else begin
      state          <= state_n;
      tx_trigger_out <= go_c;
      busy_out       <= busy_n_c;
      if (go_c) tx_data_out <= sync_due_c ? SYNC : head;
      if (go_c && sync_due_c) sync_sent <= 1'b1;
      if (pop_c) begin
        sync_sent <= 1'b0;
        frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + FRM_W'(1);
      end
      if (drop_c && (drop_count_out != '1)) drop_count_out <= drop_count_out + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_uart_framer.sv
// Scoreboard bench: stimulus queues expected transmitter words, a monitor checks each trigger.
module tb_sample_uart_framer;

  localparam int unsigned NB       = 2;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned FLEN     = 4;
  localparam int unsigned BUSY_LEN = 6;
  localparam int unsigned TMO      = 2000;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [15:0]      sample_in;
  logic             sample_valid_in;
  logic             tx_busy_in;
  logic [NB-1:0][7:0] tx_data_out;
  logic             tx_trigger_out;
  logic [4:0]       fifo_count_out;
  logic [15:0]      drop_count_out;
  logic             busy_out;

  always #5 clk_in = ~clk_in;

  sample_uart_framer #(
    .NUM_BYTES  (NB),
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FLEN)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .tx_busy_in      (tx_busy_in),
    .tx_data_out     (tx_data_out),
    .tx_trigger_out  (tx_trigger_out),
    .fifo_count_out  (fifo_count_out),
    .drop_count_out  (drop_count_out),
    .busy_out        (busy_out)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  int          mcnt  = 0;
  bit          msync = 1'b0;

  // Transmitter model: busy rises the cycle after a trigger and lasts BUSY_LEN cycles.
  logic force_busy = 1'b0;
  int   busy_cnt   = 0;
  assign tx_busy_in = force_busy || (busy_cnt != 0);
  always @(posedge clk_in) begin
    if (tx_trigger_out)     busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected-word model: clamp, then a sync ahead of every frame's first sample.
  task automatic exp_sample(input logic [15:0] s);
    logic [15:0] v;
    v = (s == 16'h8000) ? 16'h8001 : s;
    if (mcnt == 0 && !msync) begin
      exp_q.push_back(16'h8000);
      msync = 1'b1;
    end
    exp_q.push_back(v);
    msync = 1'b0;
    mcnt  = (mcnt + 1) % FLEN;
  endtask

  logic prev_trig = 1'b0;
  always @(negedge clk_in) begin
    logic [15:0] e;
    if (rst_n_in && tx_trigger_out) begin
      check("trigger_width", 32'(prev_trig), 32'h0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h expected none", tx_data_out);
      end else begin
        e = exp_q.pop_front();
        check("tx_word", 32'(tx_data_out), 32'(e));
      end
    end
    prev_trig = rst_n_in ? tx_trigger_out : 1'b0;
  end

  task automatic push(input logic [15:0] s, input bit accepted);
    if (accepted) exp_sample(s);
    sample_in       = s;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    exp_q.delete();
    mcnt  = 0;
    msync = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy_out && !tx_busy_in) && n < TMO) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (n >= TMO) begin
      bad++;
      $display("FAIL %s: drain timeout, %0d words outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(tx_data_out),    32'h0);
    check({tag, "_trig"},  32'(tx_trigger_out), 32'h0);
    check({tag, "_count"}, 32'(fifo_count_out), 32'h0);
    check({tag, "_drop"},  32'(drop_count_out), 32'h0);
    check({tag, "_busy"},  32'(busy_out),       32'h0);
  endtask

  initial begin
    int n;
    rst_n_in        = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    do_reset();
    check_reset_vals("reset");

    // Reset then first sample: sync precedes it.
    push(16'h1234, 1'b1);
    check("push_latency", 32'(fifo_count_out), 32'd1);
    drain("first_sample");

    // Idle-to-trigger latency with no sync due.
    exp_sample(16'h0042);
    sample_in       = 16'h0042;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    check("lat_t1_trig",  32'(tx_trigger_out), 32'h0);
    check("lat_t1_count", 32'(fifo_count_out), 32'd1);
    @(negedge clk_in);
    check("lat_t2_trig",  32'(tx_trigger_out), 32'h1);
    check("lat_t2_count", 32'(fifo_count_out), 32'd0);
    @(negedge clk_in);
    check("lat_t3_trig",  32'(tx_trigger_out), 32'h0);
    drain("latency");

    // Clamp.
    push(16'h8000, 1'b1);
    push(16'h7FFF, 1'b1);
    drain("clamp");

    // Frame boundary: SYNC,s0..s3,SYNC,s4..s7,SYNC,s8.
    do_reset();
    for (int i = 0; i < 9; i++) push(16'h0A00 + 16'(i), 1'b1);
    drain("frame");

    // Overflow while transmitter held busy.
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) push(16'h0B00 + 16'(i), i < DEPTH);
    @(negedge clk_in);
    check("ovf_count", 32'(fifo_count_out), 32'(DEPTH));
    check("ovf_drop",  32'(drop_count_out), 32'd3);
    check("ovf_busy",  32'(busy_out),       32'h1);
    force_busy = 1'b0;
    drain("overflow");
    check("ovf_drop_after", 32'(drop_count_out), 32'd3);

    // Full FIFO with a push on the same cycle as a pop.
    do_reset();
    push(16'h0100, 1'b1);
    drain("pre_full");
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(16'h0C00 + 16'(i), 1'b1);
    check("full_count", 32'(fifo_count_out), 32'(DEPTH));
    force_busy = 1'b0;
    push(16'h0CFF, 1'b1);
    check("fullpop_count", 32'(fifo_count_out), 32'(DEPTH));
    check("fullpop_drop",  32'(drop_count_out), 32'd0);
    check("fullpop_trig",  32'(tx_trigger_out), 32'h1);
    drain("full_pop");

    // Reset mid-transfer during WAIT_LO with 5 queued.
    do_reset();
    for (int i = 0; i < 5; i++) push(16'h0D00 + 16'(i), 1'b1);
    n = 0;
    while (!tx_busy_in && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check("midrst_reach_busy", 32'(tx_busy_in), 32'h1);
    @(negedge clk_in);
    check("midrst_queued", 32'(fifo_count_out), 32'd5);
    rst_n_in = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    mcnt  = 0;
    msync = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    n = 0;
    while (tx_busy_in && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    push(16'h0055, 1'b1);
    drain("after_midrst");

    repeat (3) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
